// File: rtl/or1k_icache_refill_ctrl_pkg.sv
// Shared types and helpers for the instruction-cache refill controller.
package or1k_icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDone  = 2'd2
    } refill_state_e;

    // Number of 32-bit words in one cache line.
    function automatic int unsigned burst_words(input int unsigned block_width);
        return 32'd1 << (block_width - 32'd2);
    endfunction

endpackage

// File: rtl/or1k_icache_refill_ctrl.sv
// Instruction-cache refill sequencer: critical-word-first wrapping burst read,
// forwarding each returned beat to the cache write port.
module or1k_icache_refill_ctrl
    import or1k_icache_refill_ctrl_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic                            refill_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [31:0]                     wrdat_o,
    output logic                            we_o,
    output logic                            imem_err_o,
    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
    output logic                            bus_last_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [31:0]                     bus_dat_i
);

    localparam int unsigned W     = OPTION_OPERAND_WIDTH;
    localparam int unsigned IdxW  = OPTION_ICACHE_BLOCK_WIDTH - 2;
    localparam int unsigned Words = burst_words(OPTION_ICACHE_BLOCK_WIDTH);
    localparam logic [IdxW-1:0] LastCnt = IdxW'(Words - 1);

    refill_state_e   state_q, state_d;
    logic [W-3:0]    adr_q, adr_d;
    logic [IdxW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            in_burst;
    logic [W-1:0]    bus_adr;

    // The byte offset within the miss word never reaches the bus.
    logic unused_adr_bits;
    assign unused_adr_bits = ^refill_adr_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            adr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        in_burst = (state_q == StBurst);

        unique case (state_q)
            StIdle: begin
                if (refill_req_i) begin
                    adr_d   = refill_adr_i[W-1:2];
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // Error takes priority over a simultaneous ack and skips DONE.
                if (bus_err_i) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (bus_ack_i) begin
                    // Only the word index advances, so the burst wraps in the line.
                    adr_d[IdxW-1:0] = adr_q[IdxW-1:0] + IdxW'(1);
                    cnt_d           = cnt_q + IdxW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        bus_adr    = in_burst ? {adr_q, 2'b00} : '0;
        bus_req_o  = in_burst;
        bus_adr_o  = bus_adr;
        bus_last_o = in_burst & (cnt_q == LastCnt);
        // Writes are suppressed once the cache has left REFILL.
        we_o       = in_burst & bus_ack_i & ~bus_err_i & refill_i;
        wradr_o    = bus_adr;
        wrdat_o    = in_burst ? bus_dat_i : 32'h0;
        imem_err_o = err_q;
    end

endmodule
